// File: rtl/run_sequencer_pkg.sv
// ============================================================================
//  Module      : run_seq_pkg
//  Description : Shared types and elaboration-time helpers for run_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package run_seq_pkg;

  // Sequencer phases
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Number of RESET cycles: the last channel releases on entry to RUN
  function automatic int total_rst_len(input int rst_cycles,
                                       input int num_ch,
                                       input int stagger);
    return rst_cycles + (num_ch - 1) * stagger;
  endfunction

  // Legal parameter combinations; checked at elaboration by the top
  function automatic bit params_ok(input int rst_cycles,
                                   input int run_cycles,
                                   input int cnt_w,
                                   input int num_ch,
                                   input int stagger,
                                   input int auto_restart);
    bit ok;
    ok = (rst_cycles >= 1) && (run_cycles >= 1) && (cnt_w >= 1) &&
         (num_ch >= 1) && (stagger >= 0) &&
         ((auto_restart == 0) || (auto_restart == 1));
    // The counter must reach RUN_CYCLES without wrapping
    if (cnt_w < 31) begin
      ok = ok && (run_cycles < (1 << cnt_w));
    end
    return ok;
  endfunction

endpackage : run_seq_pkg

`default_nettype wire

// File: rtl/run_sequencer_rst_stagger.sv
// ============================================================================
//  Module      : rst_stagger
//  Description : Registered per-channel reset outputs with staggered release.
//                Channel k releases once the RESET phase count reaches
//                RST_CYCLES + k*STAGGER, and stays released throughout RUN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_stagger #(
  parameter int RST_CYCLES = 5,
  parameter int NUM_CH     = 2,
  parameter int STAGGER    = 1,
  parameter int PH_W       = 3
) (
  input  logic              clk,
  input  logic              reset,      // asynchronous, active-low
  input  logic [PH_W-1:0]   phase_nxt,  // phase count for the coming cycle
  input  logic              reset_nxt,  // coming cycle is a RESET cycle
  input  logic              run_nxt,    // coming cycle is a RUN cycle
  output logic [NUM_CH-1:0] rst_out
);

  logic [NUM_CH-1:0] rst_out_d;
  logic [NUM_CH-1:0] rst_out_q;

  // Per-channel release decision, evaluated one cycle ahead so the output is a flop
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam logic [PH_W-1:0] THR = PH_W'(RST_CYCLES + k * STAGGER);
    assign rst_out_d[k] = ~(run_nxt | (reset_nxt & (phase_nxt >= THR)));
  end

  // Reset outputs come up asserted and reassert in IDLE/DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_out_q <= '1;
    end else begin
      rst_out_q <= rst_out_d;
    end
  end

  assign rst_out = rst_out_q;

endmodule : rst_stagger

`default_nettype wire

// File: rtl/run_sequencer.sv
// ============================================================================
//  Module      : run_sequencer
//  Description : Run controller for the main processor top. Sequences a
//                staggered reset release, a counted pausable run window with
//                done status, and optional auto-restart.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int RST_CYCLES   = 5,
  parameter int RUN_CYCLES   = 20,
  parameter int CNT_W        = 16,
  parameter int NUM_CH       = 2,
  parameter int STAGGER      = 1,
  parameter int AUTO_RESTART = 0
) (
  input  logic              clk,
  input  logic              reset,      // asynchronous, active-low
  input  logic              start,
  input  logic              hold,
  output logic [NUM_CH-1:0] rst_out,
  output logic              run_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam int RST_LEN = total_rst_len(RST_CYCLES, NUM_CH, STAGGER);
  localparam int PH_W    = $clog2(RST_LEN + 1);

  // Phase value seen in the final RESET cycle
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(RST_LEN - 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES);

  if (!params_ok(RST_CYCLES, RUN_CYCLES, CNT_W, NUM_CH, STAGGER, AUTO_RESTART)) begin : g_param_check
    $error("run_sequencer: illegal parameter combination");
  end

  state_e           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             run_q, run_d;
  logic             in_reset_d;

  // Next-state, phase counter and cycle counter decisions
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cycle_cnt_d = cycle_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RESET;
          phase_d     = '0;
          cycle_cnt_d = '0;
        end
      end
      ST_RESET: begin
        // hold and start have no effect while channels are being released
        if (phase_q == PH_LAST) begin
          state_d = ST_RUN;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      ST_RUN: begin
        if (!hold) begin
          cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
          if (cycle_cnt_d == RUN_LAST) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // Auto mode leaves after exactly one DONE cycle; single-shot waits for start
        if ((AUTO_RESTART != 0) || start) begin
          state_d     = ST_RESET;
          phase_d     = '0;
          cycle_cnt_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs are decoded from the next state so they come straight from flops
  always_comb begin
    in_reset_d = (state_d == ST_RESET);
    run_d      = (state_d == ST_RUN);
    busy_d     = in_reset_d || run_d;
    done_d     = (state_d == ST_DONE);
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      cycle_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cycle_cnt_q <= cycle_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      run_q       <= run_d;
    end
  end

  rst_stagger #(
    .RST_CYCLES (RST_CYCLES),
    .NUM_CH     (NUM_CH),
    .STAGGER    (STAGGER),
    .PH_W       (PH_W)
  ) u_rst_stagger (
    .clk       (clk),
    .reset     (reset),
    .phase_nxt (phase_d),
    .reset_nxt (in_reset_d),
    .run_nxt   (run_d),
    .rst_out   (rst_out)
  );

  // hold pauses the core combinationally so a held cycle does no work
  assign run_en    = run_q & ~hold;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule : run_sequencer

`default_nettype wire

// File: tb/tb_run_sequencer.sv
// ============================================================================
//  Module      : tb_run_sequencer
//  Description : Self-checking bench for run_sequencer. Three configurations
//                run side by side against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_run_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] start;
  logic [2:0] hold;

  always #5 clk = ~clk;

  // Instance 0: defaults
  logic [1:0]  ro0;
  logic        re0, bz0, dn0;
  logic [15:0] cc0;
  // Instance 1: four channels, stagger 2
  logic [3:0]  ro1;
  logic        re1, bz1, dn1;
  logic [7:0]  cc1;
  // Instance 2: three channels, no stagger, auto-restart
  logic [2:0]  ro2;
  logic        re2, bz2, dn2;
  logic [3:0]  cc2;

  run_sequencer u_dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .hold(hold[0]),
    .rst_out(ro0), .run_en(re0), .busy(bz0), .done(dn0), .cycle_cnt(cc0)
  );

  run_sequencer #(
    .RST_CYCLES(3), .RUN_CYCLES(7), .CNT_W(8), .NUM_CH(4), .STAGGER(2), .AUTO_RESTART(0)
  ) u_dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .hold(hold[1]),
    .rst_out(ro1), .run_en(re1), .busy(bz1), .done(dn1), .cycle_cnt(cc1)
  );

  run_sequencer #(
    .RST_CYCLES(2), .RUN_CYCLES(5), .CNT_W(4), .NUM_CH(3), .STAGGER(0), .AUTO_RESTART(1)
  ) u_dut2 (
    .clk(clk), .reset(reset), .start(start[2]), .hold(hold[2]),
    .rst_out(ro2), .run_en(re2), .busy(bz2), .done(dn2), .cycle_cnt(cc2)
  );

  logic [63:0] g_rst [3];
  logic [63:0] g_ren [3];
  logic [63:0] g_bsy [3];
  logic [63:0] g_dne [3];
  logic [63:0] g_cnt [3];

  assign g_rst[0] = 64'(ro0);  assign g_rst[1] = 64'(ro1);  assign g_rst[2] = 64'(ro2);
  assign g_ren[0] = 64'(re0);  assign g_ren[1] = 64'(re1);  assign g_ren[2] = 64'(re2);
  assign g_bsy[0] = 64'(bz0);  assign g_bsy[1] = 64'(bz1);  assign g_bsy[2] = 64'(bz2);
  assign g_dne[0] = 64'(dn0);  assign g_dne[1] = 64'(dn1);  assign g_dne[2] = 64'(dn2);
  assign g_cnt[0] = 64'(cc0);  assign g_cnt[1] = 64'(cc1);  assign g_cnt[2] = 64'(cc2);

  // Configuration of each instance, as seen by the model
  int c_rst  [3] = '{5, 3, 2};
  int c_run  [3] = '{20, 7, 5};
  int c_nch  [3] = '{2, 4, 3};
  int c_stg  [3] = '{1, 2, 0};
  int c_auto [3] = '{0, 0, 1};

  // Model: mode 0 idle, 1 reset, 2 run, 3 done; rj = 1-based RESET cycle index
  int m_mode [3];
  int m_rj   [3];
  int m_cc   [3];

  int n_vec = 0;
  int n_bad = 0;

  // Observations of instance 0 from the most recent check, used by directed timing
  logic        snap_done0;
  logic [63:0] snap_cc0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_rst(input int n);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < c_nch[n]; k++) begin
      if (m_mode[n] == 2)      v[k] = 1'b0;
      else if (m_mode[n] == 1) v[k] = (m_rj[n] <= c_rst[n] + k * c_stg[n]);
      else                     v[k] = 1'b1;
    end
    return v;
  endfunction

  function automatic void model_reset();
    for (int n = 0; n < 3; n++) begin
      m_mode[n] = 0;
      m_rj[n]   = 0;
      m_cc[n]   = 0;
    end
  endfunction

  function automatic void model_step(input int n, input bit st, input bit hd);
    case (m_mode[n])
      0: if (st) begin m_mode[n] = 1; m_rj[n] = 1; m_cc[n] = 0; end
      1: begin
        // RESET ends on the cycle in which the last channel's count is reached
        if (m_rj[n] == c_rst[n] + (c_nch[n] - 1) * c_stg[n]) m_mode[n] = 2;
        else m_rj[n]++;
      end
      2: if (!hd) begin
        m_cc[n]++;
        if (m_cc[n] == c_run[n]) m_mode[n] = 3;
      end
      default: if (c_auto[n] != 0 || st) begin m_mode[n] = 1; m_rj[n] = 1; m_cc[n] = 0; end
    endcase
  endfunction

  task automatic check_all();
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("d%0d.rst_out", n),   g_rst[n], exp_rst(n));
      chk($sformatf("d%0d.run_en", n),    g_ren[n], 64'((m_mode[n] == 2) && !hold[n]));
      chk($sformatf("d%0d.busy", n),      g_bsy[n], 64'((m_mode[n] == 1) || (m_mode[n] == 2)));
      chk($sformatf("d%0d.done", n),      g_dne[n], 64'(m_mode[n] == 3));
      chk($sformatf("d%0d.cycle_cnt", n), g_cnt[n], 64'(m_cc[n]));
    end
    snap_done0 = dn0;
    snap_cc0   = g_cnt[0];
  endtask

  // One clock: drive at the falling edge, check, then advance the model at the rising edge
  task automatic cycle(input logic [2:0] st, input logic [2:0] hd);
    @(negedge clk);
    start = st;
    hold  = hd;
    #1;
    check_all();
    @(posedge clk);
    for (int n = 0; n < 3; n++) model_step(n, st[n], hd[n]);
  endtask

  // Asynchronous reset pulse between clock edges
  task automatic do_reset();
    @(negedge clk);
    start = '0;
    hold  = '0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  // Start instance 0 and measure cycles from the start edge until done is seen
  task automatic run_timed(input string tag, input int hold_at, input int hold_len,
                           input bit spurious, input int exp_lat);
    int lat;
    bit st, hd;
    lat = 0;
    cycle(3'b001, 3'b000);
    for (int i = 1; i <= 100; i++) begin
      hd = (i >= hold_at) && (i < hold_at + hold_len);
      st = spurious && ((i == 3) || (i == 15));
      cycle({2'b00, st}, {2'b00, hd});
      if (snap_done0 === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk(tag, 64'(lat), 64'(exp_lat));
    chk({tag, ".cnt"}, snap_cc0, 64'd20);
  endtask

  initial begin
    int waited;
    reset = 1'b0;
    start = '0;
    hold  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 check_all();
    #1 reset = 1'b1;

    // Directed timing on the default instance
    run_timed("lat_plain", 1000, 0, 1'b0, 27);
    run_timed("lat_hold3", 10, 3, 1'b0, 30);
    run_timed("lat_spurious_start", 1000, 0, 1'b1, 27);

    // Reset mid-RUN at cycle_cnt 10, then a full sequence again
    cycle(3'b001, 3'b000);
    waited = 0;
    while (snap_cc0 != 64'd10 && waited < 100) begin
      cycle(3'b000, 3'b000);
      waited++;
    end
    chk("reach_cnt10", snap_cc0, 64'd10);
    do_reset();
    run_timed("lat_after_reset", 1000, 0, 1'b0, 27);

    // Random traffic on all three instances
    for (int c = 0; c < 3000; c++) begin
      logic [2:0] st, hd;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        for (int n = 0; n < 3; n++) begin
          st[n] = ($urandom_range(0, 3) == 0);
          hd[n] = ($urandom_range(0, 2) == 0);
        end
        cycle(st, hd);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_run_sequencer

`default_nettype wire
